// File: rtl/jc_phase_monitor.sv
// Johnson-counter phase monitor.
// Decodes a 4-bit Johnson code into a phase index. It hunts for a run of
// correct successors and reports lock. While locked it flags sequence errors,
// flywheels over illegal codes and counts completed 8-phase cycles.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   jc_in, jc_vld   Johnson code sample and its qualifier
//   phase           decoded phase index of the last legal valid sample
//   phase_vld       pulse: phase was updated
//   illegal         pulse: the valid sample was not a legal code
//   seq_err         pulse: sequence error while locked
//   locked          level: FSM is in LOCKED
//   cycle_cnt       completed 8-phase cycles while locked (wraps)
//   err_cnt         seq_err events (saturates)
module jc_phase_monitor #(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_ERR = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] jc_in,
  input  logic       jc_vld,
  output logic [2:0] phase,
  output logic       phase_vld,
  output logic       illegal,
  output logic       seq_err,
  output logic       locked,
  output logic [7:0] cycle_cnt,
  output logic [7:0] err_cnt
);

  localparam int unsigned PW = 3;
  localparam int unsigned CW = 4;
  localparam int unsigned NW = 8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HUNT   = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [PW-1:0] ref_ph, ref_nxt;
  logic [CW-1:0] good_cnt, good_nxt;
  logic [CW-1:0] miss_cnt, miss_nxt;
  logic [PW-1:0] phase_nxt;
  logic          pv_nxt, il_nxt, se_nxt, lk_nxt;
  logic [NW-1:0] cyc_nxt, err_nxt;

  logic          dec_legal;
  logic [PW-1:0] dec_phase;
  logic          is_succ;
  logic          is_wrap;
  logic [CW-1:0] good_inc;
  logic [CW-1:0] miss_inc;

  // Johnson code to phase index decode
  always_comb begin
    dec_legal = 1'b1;
    dec_phase = '0;
    case (jc_in)
      4'b0000: dec_phase = 3'd0;
      4'b1000: dec_phase = 3'd1;
      4'b1100: dec_phase = 3'd2;
      4'b1110: dec_phase = 3'd3;
      4'b1111: dec_phase = 3'd4;
      4'b0111: dec_phase = 3'd5;
      4'b0011: dec_phase = 3'd6;
      4'b0001: dec_phase = 3'd7;
      default: dec_legal = 1'b0;
    endcase
  end

  // Successor test against the reference phase; wrap marks a 7->0 step
  assign is_succ  = dec_legal && (dec_phase == PW'(ref_ph + 3'd1));
  assign is_wrap  = is_succ && (dec_phase == 3'd0);
  assign good_inc = CW'(good_cnt + 4'd1);
  assign miss_inc = CW'(miss_cnt + 4'd1);

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    ref_nxt   = ref_ph;
    good_nxt  = good_cnt;
    miss_nxt  = miss_cnt;
    phase_nxt = phase;
    pv_nxt    = 1'b0;
    il_nxt    = 1'b0;
    se_nxt    = 1'b0;
    cyc_nxt   = cycle_cnt;
    err_nxt   = err_cnt;

    if (jc_vld) begin
      il_nxt = !dec_legal;
      if (dec_legal) begin
        phase_nxt = dec_phase;
        pv_nxt    = 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (dec_legal) begin
            state_nxt = S_HUNT;
            ref_nxt   = dec_phase;
            good_nxt  = '0;
          end
        end

        S_HUNT: begin
          if (!dec_legal) begin
            state_nxt = S_IDLE;
            good_nxt  = '0;
          end else if (is_succ) begin
            ref_nxt  = dec_phase;
            good_nxt = good_inc;
            if (good_inc == CW'(LOCK_CNT)) begin
              state_nxt = S_LOCKED;
              miss_nxt  = '0;
              // the locking sample itself may complete a cycle
              if (is_wrap) cyc_nxt = NW'(cycle_cnt + 8'd1);
            end
          end else begin
            ref_nxt  = dec_phase;
            good_nxt = '0;
          end
        end

        S_LOCKED: begin
          if (is_succ) begin
            ref_nxt  = dec_phase;
            miss_nxt = '0;
            if (is_wrap) cyc_nxt = NW'(cycle_cnt + 8'd1);
          end else begin
            se_nxt = 1'b1;
            if (err_cnt != 8'hFF) err_nxt = NW'(err_cnt + 8'd1);
            // illegal code: advance the reference as if the expected phase arrived
            ref_nxt = dec_legal ? dec_phase : PW'(ref_ph + 3'd1);
            if (miss_inc == CW'(UNLOCK_ERR)) begin
              state_nxt = dec_legal ? S_HUNT : S_IDLE;
              good_nxt  = '0;
              miss_nxt  = '0;
            end else begin
              miss_nxt = miss_inc;
            end
          end
        end

        default: state_nxt = S_IDLE;
      endcase
    end

    lk_nxt = (state_nxt == S_LOCKED);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ref_ph    <= '0;
      good_cnt  <= '0;
      miss_cnt  <= '0;
      phase     <= '0;
      phase_vld <= 1'b0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
      locked    <= 1'b0;
      cycle_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      ref_ph    <= ref_nxt;
      good_cnt  <= good_nxt;
      miss_cnt  <= miss_nxt;
      phase     <= phase_nxt;
      phase_vld <= pv_nxt;
      illegal   <= il_nxt;
      seq_err   <= se_nxt;
      locked    <= lk_nxt;
      cycle_cnt <= cyc_nxt;
      err_cnt   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_jc_phase_monitor.sv
// Scoreboard bench for jc_phase_monitor: stimulus pushes the expected
// response of each sample; a monitor pops and compares one cycle later.
module tb_jc_phase_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] jc_in;
  logic       jc_vld;
  logic [2:0] phase;
  logic       phase_vld, illegal, seq_err, locked;
  logic [7:0] cycle_cnt, err_cnt;

  jc_phase_monitor #(.LOCK_CNT(4), .UNLOCK_ERR(2)) dut (
    .clk(clk), .rst_n(rst_n), .jc_in(jc_in), .jc_vld(jc_vld),
    .phase(phase), .phase_vld(phase_vld), .illegal(illegal),
    .seq_err(seq_err), .locked(locked), .cycle_cnt(cycle_cnt),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ph;
    logic       pv;
    logic       il;
    logic       se;
    logic       lk;
    logic [7:0] cyc;
    logic [7:0] err;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   e_cyc = 0;
  int   e_err = 0;
  bit   take  = 1'b0;

  function automatic logic [3:0] code_of(input int p);
    case (p)
      0: return 4'b0000;
      1: return 4'b1000;
      2: return 4'b1100;
      3: return 4'b1110;
      4: return 4'b1111;
      5: return 4'b0111;
      6: return 4'b0011;
      default: return 4'b0001;
    endcase
  endfunction

  task automatic send(input logic r, input logic v, input logic [3:0] c,
                      input int ph, input logic pv, input logic il,
                      input logic se, input logic lk, input string tag);
    exp_t e;
    @(negedge clk);
    rst_n  = r;
    jc_vld = v;
    jc_in  = c;
    e.ph  = 3'(ph);
    e.pv  = pv;
    e.il  = il;
    e.se  = se;
    e.lk  = lk;
    e.cyc = 8'(e_cyc);
    e.err = 8'(e_err);
    e.tag = tag;
    q.push_back(e);
  endtask

  // Clean locked steps starting after phase 'from'
  task automatic run_locked(input int from, input int n, input string tag);
    for (int k = 1; k <= n; k++) begin
      int p;
      p = (from + k) % 8;
      if (p == 0) e_cyc = (e_cyc + 1) % 256;
      send(1, 1, code_of(p), p, 1, 0, 0, 1, tag);
    end
  endtask

  // Monitor: a sample driven before a rising edge is checked at the next falling edge
  always @(posedge clk) take = (q.size() != 0);

  always @(negedge clk) begin
    if (take) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (phase !== e.ph || phase_vld !== e.pv || illegal !== e.il ||
          seq_err !== e.se || locked !== e.lk || cycle_cnt !== e.cyc ||
          err_cnt !== e.err) begin
        bad++;
        $display("FAIL %s: got ph=%0d pv=%b il=%b se=%b lk=%b cyc=%0d err=%0d exp ph=%0d pv=%b il=%b se=%b lk=%b cyc=%0d err=%0d",
                 e.tag, phase, phase_vld, illegal, seq_err, locked, cycle_cnt, err_cnt,
                 e.ph, e.pv, e.il, e.se, e.lk, e.cyc, e.err);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lastp;
    rst_n  = 1'b0;
    jc_vld = 1'b0;
    jc_in  = 4'b0000;

    // reset state
    send(0, 0, 4'b0000, 0, 0, 0, 0, 0, "reset0");
    send(0, 1, 4'b1000, 0, 0, 0, 0, 0, "reset1");

    // clean lock from reset
    send(1, 1, 4'b0000, 0, 1, 0, 0, 0, "lock_p0");
    send(1, 1, 4'b1000, 1, 1, 0, 0, 0, "lock_p1");
    send(1, 1, 4'b1100, 2, 1, 0, 0, 0, "lock_p2");
    send(1, 1, 4'b1110, 3, 1, 0, 0, 0, "lock_p3");
    send(1, 1, 4'b1111, 4, 1, 0, 0, 1, "lock_p4");

    // 17 further steps: two 7->0 wraps
    run_locked(4, 17, "run17");
    // now at phase 5, cycle_cnt=2; advance to phase 2 (one more wrap)
    run_locked(5, 5, "to_p2");

    // illegal while locked: flywheel keeps expecting 4 next
    e_err = 1;
    send(1, 1, 4'b1010, 2, 0, 1, 1, 1, "lk_illegal");
    send(1, 1, 4'b1111, 4, 1, 0, 0, 1, "flywheel_ok");

    // to phase 3, then two consecutive misses
    run_locked(4, 7, "to_p3");
    e_err = 2;
    send(1, 1, 4'b0111, 5, 1, 0, 1, 1, "miss1");
    e_err = 3;
    send(1, 1, 4'b0000, 0, 1, 0, 1, 0, "miss2_unlock");
    send(1, 1, 4'b1000, 1, 1, 0, 0, 0, "hunt_g1");
    send(1, 1, 4'b1100, 2, 1, 0, 0, 0, "hunt_g2");
    send(1, 1, 4'b1110, 3, 1, 0, 0, 0, "hunt_g3");
    send(1, 1, 4'b1111, 4, 1, 0, 0, 1, "relock");
    run_locked(4, 4, "to_cyc5");

    // valid low with garbage codes: nothing moves
    send(1, 0, 4'b1010, 0, 0, 0, 0, 1, "novld0");
    send(1, 0, 4'b0101, 0, 0, 0, 0, 1, "novld1");
    send(1, 0, 4'b1111, 0, 0, 0, 0, 1, "novld2");
    send(1, 0, 4'b0011, 0, 0, 0, 0, 1, "novld3");
    send(1, 0, 4'b1001, 0, 0, 0, 0, 1, "novld4");
    send(1, 1, 4'b1000, 1, 1, 0, 0, 1, "after_novld");

    // reset mid-lock overrides a valid successor
    e_cyc = 0;
    e_err = 0;
    send(0, 1, 4'b1100, 0, 0, 0, 0, 0, "mid_reset");
    send(1, 1, 4'b1100, 2, 1, 0, 0, 0, "post_rst_idle");
    send(1, 1, 4'b1110, 3, 1, 0, 0, 0, "post_rst_g1");
    send(1, 1, 4'b1111, 4, 1, 0, 0, 0, "post_rst_g2");
    // legal non-successor in HUNT restarts the run
    send(1, 1, 4'b0000, 0, 1, 0, 0, 0, "hunt_nonsucc");
    send(1, 1, 4'b1000, 1, 1, 0, 0, 0, "hunt_r1");
    send(1, 1, 4'b1100, 2, 1, 0, 0, 0, "hunt_r2");
    send(1, 1, 4'b1110, 3, 1, 0, 0, 0, "hunt_r3");
    send(1, 1, 4'b1111, 4, 1, 0, 0, 1, "hunt_r4_lock");

    // illegal in IDLE path and counter boundaries: two illegals drop to IDLE,
    // then relock on a 7->0 step (counts a cycle); cycle_cnt wraps, err_cnt saturates
    lastp = 4;
    for (int it = 0; it < 260; it++) begin
      e_err = (e_err < 255) ? e_err + 1 : 255;
      send(1, 1, 4'b1010, lastp, 0, 1, 1, 1, "loop_bad1");
      e_err = (e_err < 255) ? e_err + 1 : 255;
      send(1, 1, 4'b0101, lastp, 0, 1, 1, 0, "loop_bad2");
      send(1, 1, 4'b1011, lastp, 0, 1, 0, 0, "loop_idle_ill");
      send(1, 1, code_of(4), 4, 1, 0, 0, 0, "loop_p4");
      send(1, 1, code_of(5), 5, 1, 0, 0, 0, "loop_p5");
      send(1, 1, code_of(6), 6, 1, 0, 0, 0, "loop_p6");
      send(1, 1, code_of(7), 7, 1, 0, 0, 0, "loop_p7");
      e_cyc = (e_cyc + 1) % 256;
      send(1, 1, code_of(0), 0, 1, 0, 0, 1, "loop_lock_wrap");
      lastp = 0;
    end

    // drain: scoreboard must be empty
    send(1, 0, 4'b0000, 0, 0, 0, 0, 1, "final_idle");
    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending exp 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
